// File: rtl/abc_seq_pkg.sv
// abc_seq_pkg: shared types, constants and next-state function for the a/b/c sequence checker
package abc_seq_pkg;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} chk_state_t;

    localparam logic [2:0] STUCK_A = 3'b110;
    localparam logic [2:0] STUCK_B = 3'b011;

    // s = {a,b,c}; returns {a',b',c'} with a'=~(c&b), b'=a|c, c'=a^b
    function automatic logic [2:0] abc_next(input logic [2:0] s);
        return {~(s[0] & s[1]), s[2] | s[0], s[2] ^ s[1]};
    endfunction

endpackage

// File: rtl/abc_seq_predict.sv
// abc_seq_predict: predicts the next {a,b,c} from the previous sample and the expected y of the current one
// Ports:
//   prev_i  [2:0]  previous {a,b,c} sample
//   ab_i    [1:0]  current {a,b}
//   pred_o  [2:0]  predicted current {a,b,c}
//   y_o            expected y for the current sample (a | b)
module abc_seq_predict
    import abc_seq_pkg::*;
(
    input  logic [2:0] prev_i,
    input  logic [1:0] ab_i,
    output logic [2:0] pred_o,
    output logic       y_o
);

    assign pred_o = abc_next(prev_i);
    assign y_o    = ab_i[1] | ab_i[0];

endmodule

// File: rtl/abc_sequence_checker.sv
// abc_sequence_checker: locks onto the a/b/c generator stream, counts errors while locked, flags stuck states
// Ports:
//   clk, reset (async, active-low), clear (sync clear), in_valid (sample qualifier)
//   a_in, b_in, c_in, y_in   generator sample
//   locked      1 while in LOCKED
//   mismatch    1-cycle pulse, a/b/c differed from prediction while LOCKED
//   y_err       1-cycle pulse, y_in != a_in | b_in (any state)
//   stuck       sticky, a sample of 110 or 011 was seen
//   err_count   saturating count of LOCKED-state errors
//   fsm_state   HUNT=0, SYNC=1, LOCKED=2
module abc_sequence_checker
    import abc_seq_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             c_in,
    input  logic             y_in,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic             y_err,
    output logic             stuck,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fsm_state
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);

    chk_state_t        state_q;
    logic [2:0]        prev_q;
    logic [RUN_W-1:0]  run_q;
    logic [MISS_W-1:0] miss_q;
    logic              locked_q, mismatch_q, y_err_q, stuck_q;
    logic [ERR_W-1:0]  err_q;

    logic [2:0]       sample, pred;
    logic             y_exp, match_d, y_bad_d, stuck_d;
    logic [ERR_W-1:0] err_d;

    assign sample = {a_in, b_in, c_in};

    abc_seq_predict u_predict (
        .prev_i (prev_q),
        .ab_i   ({a_in, b_in}),
        .pred_o (pred),
        .y_o    (y_exp)
    );

    assign match_d = sample == pred;
    assign y_bad_d = y_in != y_exp;
    assign stuck_d = sample == STUCK_A || sample == STUCK_B;
    assign err_d   = &err_q ? err_q : err_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            prev_q     <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            y_err_q    <= 1'b0;
            stuck_q    <= 1'b0;
            err_q      <= '0;
        end else if (clear) begin
            state_q    <= HUNT;
            prev_q     <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            y_err_q    <= 1'b0;
            stuck_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= 1'b0;
            y_err_q    <= 1'b0;
            if (in_valid) begin
                prev_q  <= sample;
                y_err_q <= y_bad_d;
                if (stuck_d) stuck_q <= 1'b1;
                case (state_q)
                    HUNT: begin
                        state_q <= SYNC;
                        run_q   <= '0;
                    end
                    SYNC: begin
                        if (!match_d) run_q <= '0;
                        else if (run_q == RUN_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            miss_q   <= '0;
                        end else run_q <= run_q + 1'b1;
                    end
                    LOCKED: begin
                        mismatch_q <= !match_d;
                        if (!match_d || y_bad_d) err_q <= err_d;
                        // a matched sample with only a y error neither clears nor advances the miss run
                        if (!match_d) begin
                            if (miss_q == MISS_LAST) begin
                                state_q  <= SYNC;
                                locked_q <= 1'b0;
                                run_q    <= '0;
                            end else miss_q <= miss_q + 1'b1;
                        end else if (!y_bad_d) miss_q <= '0;
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign y_err     = y_err_q;
    assign stuck     = stuck_q;
    assign err_count = err_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_abc_sequence_checker.sv
// tb_abc_sequence_checker: directed-vector bench for abc_sequence_checker (default and ERR_W=2 instances)
module tb_abc_sequence_checker;

    logic       clk = 1'b0;
    logic       reset, in_valid, a_in, b_in, c_in, y_in, clear;
    logic       locked, mismatch, y_err, stuck;
    logic [7:0] err_count;
    logic [1:0] fsm_state;
    logic       locked2, mismatch2, y_err2, stuck2;
    logic [1:0] err_count2, fsm_state2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    abc_sequence_checker dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .y_in(y_in), .clear(clear),
        .locked(locked), .mismatch(mismatch), .y_err(y_err), .stuck(stuck),
        .err_count(err_count), .fsm_state(fsm_state)
    );

    abc_sequence_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .y_in(y_in), .clear(clear),
        .locked(locked2), .mismatch(mismatch2), .y_err(y_err2), .stuck(stuck2),
        .err_count(err_count2), .fsm_state(fsm_state2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic lk, input logic mm, input logic ye,
                              input logic st, input logic [7:0] ec, input logic [1:0] fs,
                              input logic [1:0] ec2);
        check({tag, ".locked"}, 32'(locked), 32'(lk));
        check({tag, ".mismatch"}, 32'(mismatch), 32'(mm));
        check({tag, ".y_err"}, 32'(y_err), 32'(ye));
        check({tag, ".stuck"}, 32'(stuck), 32'(st));
        check({tag, ".err_count"}, 32'(err_count), 32'(ec));
        check({tag, ".fsm_state"}, 32'(fsm_state), 32'(fs));
        check({tag, ".err_count_w2"}, 32'(err_count2), 32'(ec2));
    endtask

    task automatic drive(input logic [2:0] s, input logic y, input logic v = 1'b1, input logic clr = 1'b0);
        {a_in, b_in, c_in} = s;
        y_in     = y;
        in_valid = v;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] s;
        logic       y;
        logic       ye;
        logic [7:0] ec;
        logic [1:0] ec2;
    } vec_t;

    vec_t sat_tab[10];

    initial begin
        reset = 1'b0; in_valid = 1'b0; clear = 1'b0;
        a_in = 1'b0; b_in = 1'b0; c_in = 1'b0; y_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 8'd0, 2'd0, 2'd0);
        reset = 1'b1;

        // lock onto the legal cycle
        drive(3'b000, 0); expect_out("t1.s1", 0, 0, 0, 0, 8'd0, 2'd1, 2'd0);
        drive(3'b100, 1); expect_out("t1.s2", 0, 0, 0, 0, 8'd0, 2'd1, 2'd0);
        drive(3'b111, 1); expect_out("t1.s3", 0, 0, 0, 0, 8'd0, 2'd1, 2'd0);
        drive(3'b010, 1); expect_out("t1.s4", 1, 0, 0, 0, 8'd0, 2'd2, 2'd0);
        drive(3'b101, 1); expect_out("t1.s5", 1, 0, 0, 0, 8'd0, 2'd2, 2'd0);

        // single mismatch while locked
        drive(3'b111, 1); expect_out("t2.s1", 1, 0, 0, 0, 8'd0, 2'd2, 2'd0);
        drive(3'b111, 1); expect_out("t2.s2", 1, 1, 0, 0, 8'd1, 2'd2, 2'd1);
        drive(3'b010, 1); expect_out("t2.s3", 1, 0, 0, 0, 8'd1, 2'd2, 2'd1);

        // two consecutive mismatches drop to SYNC
        drive(3'b101, 1); expect_out("t3.s1", 1, 0, 0, 0, 8'd1, 2'd2, 2'd1);
        drive(3'b111, 1); expect_out("t3.s2", 1, 0, 0, 0, 8'd1, 2'd2, 2'd1);
        drive(3'b000, 0); expect_out("t3.s3", 1, 1, 0, 0, 8'd2, 2'd2, 2'd2);
        drive(3'b000, 0); expect_out("t3.s4", 0, 1, 0, 0, 8'd3, 2'd1, 2'd3);

        // stuck fixed point 110; SYNC mismatch gives no pulse
        drive(3'b110, 1); expect_out("t4.s1", 0, 0, 0, 1, 8'd3, 2'd1, 2'd3);
        drive(3'b110, 1); expect_out("t4.s2", 0, 0, 0, 1, 8'd3, 2'd1, 2'd3);
        drive(3'b110, 1); expect_out("t4.s3", 0, 0, 0, 1, 8'd3, 2'd1, 2'd3);
        drive(3'b110, 1); expect_out("t4.s4", 1, 0, 0, 1, 8'd3, 2'd2, 2'd3);
        // clear beats a valid stuck sample
        drive(3'b110, 1, 1, 1); expect_out("t4.clear", 0, 0, 0, 0, 8'd0, 2'd0, 2'd0);

        // y error in HUNT pulses but does not count; relock
        drive(3'b000, 1); expect_out("t5.hunt", 0, 0, 1, 0, 8'd0, 2'd1, 2'd0);
        drive(3'b100, 1); drive(3'b111, 1);
        drive(3'b010, 1); expect_out("t5.lock", 1, 0, 0, 0, 8'd0, 2'd2, 2'd0);
        drive(3'b101, 0); expect_out("t5.yerr", 1, 0, 1, 0, 8'd1, 2'd2, 2'd1);

        sat_tab = '{
            '{3'b111, 0, 1, 8'd2, 2'd2}, '{3'b010, 1, 0, 8'd2, 2'd2},
            '{3'b101, 0, 1, 8'd3, 2'd3}, '{3'b111, 1, 0, 8'd3, 2'd3},
            '{3'b010, 0, 1, 8'd4, 2'd3}, '{3'b101, 1, 0, 8'd4, 2'd3},
            '{3'b111, 0, 1, 8'd5, 2'd3}, '{3'b010, 1, 0, 8'd5, 2'd3},
            '{3'b101, 0, 1, 8'd6, 2'd3}, '{3'b111, 1, 0, 8'd6, 2'd3}
        };
        foreach (sat_tab[i]) begin
            drive(sat_tab[i].s, sat_tab[i].y);
            expect_out($sformatf("t5.sat%0d", i), 1, 0, sat_tab[i].ye, 0, sat_tab[i].ec, 2'd2, sat_tab[i].ec2);
        end

        // valid low holds everything, even with a stuck-looking bad sample on the pins
        for (int i = 0; i < 10; i++) begin
            drive(3'b011, 0, 0);
            expect_out($sformatf("t6.hold%0d", i), 1, 0, 0, 0, 8'd6, 2'd2, 2'd3);
        end
        drive(3'b010, 1); expect_out("t6.resume", 1, 0, 0, 0, 8'd6, 2'd2, 2'd3);

        // asynchronous reset between clock edges
        #3 reset = 1'b0;
        #1 expect_out("t6.areset", 0, 0, 0, 0, 8'd0, 2'd0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(3'b000, 0); expect_out("t6.after", 0, 0, 0, 0, 8'd0, 2'd1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
